// File: rtl/id_pkg.sv
// Shared definitions for the ID issue controller: opcode and funct
// encodings, the issue FSM state type and a small decode helper.
package id_pkg;

    localparam logic [5:0] OP_ALU = 6'b101010;
    localparam logic [5:0] OP_LD  = 6'b100000;
    localparam logic [5:0] OP_ST  = 6'b100001;
    localparam logic [5:0] OP_NOP = 6'b111100;

    // ALU funct codes whose rB field carries an immediate
    localparam logic [3:0] FN_IMM_A = 4'b1011;
    localparam logic [3:0] FN_IMM_B = 4'b1101;
    localparam logic [3:0] FN_IMM_C = 4'b1111;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HAZARD = 2'd1,
        OFFER  = 2'd2
    } state_t;

    function automatic logic is_imm_funct(input logic [3:0] funct);
        return (funct == FN_IMM_A) || (funct == FN_IMM_B) || (funct == FN_IMM_C);
    endfunction

endpackage

// File: rtl/id_reg_use_dec.sv
// Register-use decode: which architectural registers an instruction reads
// and writes. Pure combinational; instantiated once for the held
// instruction and once for the incoming one.
module id_reg_use_dec
    import id_pkg::*;
(
    input  logic [0:31] instr,
    output logic        rd_a_en,
    output logic [4:0]  rd_a,
    output logic        rd_b_en,
    output logic [4:0]  rd_b,
    output logic        wr_en,
    output logic [4:0]  wr_rd
);

    logic [5:0] opcode;
    logic [3:0] funct;
    logic       unused_bits;

    assign opcode      = instr[0:5];
    assign funct       = instr[28:31];
    assign unused_bits = ^instr[21:27];

    // Field extraction and enable decode per opcode class
    always_comb begin
        rd_a_en = 1'b0;
        rd_a    = instr[11:15];
        rd_b_en = 1'b0;
        rd_b    = instr[16:20];
        wr_en   = 1'b0;
        wr_rd   = instr[6:10];
        case (opcode)
            OP_ALU: begin
                rd_a_en = 1'b1;
                rd_b_en = !is_imm_funct(funct);
                wr_en   = 1'b1;
            end
            OP_LD: begin
                wr_en = 1'b1;
            end
            OP_ST: begin
                // store data register sits in the rD field
                rd_a_en = 1'b1;
                rd_a    = instr[6:10];
            end
            OP_NOP: begin
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// Issue sequencer between fetch and ID. Holds one instruction, stalls it
// while any of its registers has a write in flight, then offers it to ID.
// Optional build macro: ID_STALL_CNT_EN adds a saturating hazard-cycle
// counter on stall_cnt; without it stall_cnt is tied to zero.
//
// state  | meaning
// EMPTY  | no instruction held, fetch may deliver
// HAZARD | held instruction waits on a busy register
// OFFER  | held instruction presented to ID
module id_issue_ctrl
    import id_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    input  logic [0:31]         if_instr,
    output logic                if_ready,
    output logic                id_valid,
    output logic [0:31]         id_instr,
    input  logic                id_ready,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
    input  logic                flush,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam logic [NUM_REGS-1:0] REG_ONE = NUM_REGS'(1);

    state_t              state;
    state_t              state_nxt;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [NUM_REGS-1:0] wb_clr;
    logic [NUM_REGS-1:0] issue_set;
    logic [0:31]         instr_q;
    logic                id_valid_q;
    logic                stall_q;
    logic                capture;
    logic                issue;
    logic                hz_held;
    logic                hz_new;

    logic       h_rd_a_en, h_rd_b_en, h_wr_en;
    logic [4:0] h_rd_a, h_rd_b, h_wr_rd;
    logic       n_rd_a_en, n_rd_b_en, n_wr_en;
    logic [4:0] n_rd_a, n_rd_b, n_wr_rd;

    id_reg_use_dec u_dec_held (
        .instr   (instr_q),
        .rd_a_en (h_rd_a_en),
        .rd_a    (h_rd_a),
        .rd_b_en (h_rd_b_en),
        .rd_b    (h_rd_b),
        .wr_en   (h_wr_en),
        .wr_rd   (h_wr_rd)
    );

    id_reg_use_dec u_dec_new (
        .instr   (if_instr),
        .rd_a_en (n_rd_a_en),
        .rd_a    (n_rd_a),
        .rd_b_en (n_rd_b_en),
        .rd_b    (n_rd_b),
        .wr_en   (n_wr_en),
        .wr_rd   (n_wr_rd)
    );

    function automatic logic hazard_of(
        input logic [NUM_REGS-1:0] mask,
        input logic                a_en,
        input logic [4:0]          a,
        input logic                b_en,
        input logic [4:0]          b,
        input logic                w_en,
        input logic [4:0]          w
    );
        return (a_en && mask[a]) || (b_en && mask[b]) || (w_en && mask[w]);
    endfunction

    assign if_ready  = !flush && ((state == EMPTY) || ((state == OFFER) && id_ready));
    assign capture   = if_valid && if_ready;
    assign issue     = (state == OFFER) && id_ready && !flush;
    assign wb_clr    = wb_valid ? (REG_ONE << wb_rd) : '0;
    assign issue_set = (issue && h_wr_en) ? (REG_ONE << h_wr_rd) : '0;
    // write-back bypass first, then the issue set so set wins on a tie;
    // the incoming instruction is checked against this same mask
    assign busy_nxt  = (busy_q & ~wb_clr) | issue_set;
    assign hz_held   = hazard_of(busy_nxt, h_rd_a_en, h_rd_a, h_rd_b_en, h_rd_b, h_wr_en, h_wr_rd);
    assign hz_new    = hazard_of(busy_nxt, n_rd_a_en, n_rd_a, n_rd_b_en, n_rd_b, n_wr_en, n_wr_rd);

    // Next-state selection; flush overrides capture and issue
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (capture) state_nxt = hz_new ? HAZARD : OFFER;
                end
                HAZARD: begin
                    if (!hz_held) state_nxt = OFFER;
                end
                OFFER: begin
                    if (id_ready) begin
                        if (capture) state_nxt = hz_new ? HAZARD : OFFER;
                        else         state_nxt = EMPTY;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // FSM state, held instruction, scoreboard and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            busy_q     <= '0;
            instr_q    <= '0;
            id_valid_q <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy_q     <= busy_nxt;
            if (capture) instr_q <= if_instr;
            id_valid_q <= (state_nxt == OFFER);
            stall_q    <= (state_nxt == HAZARD);
        end
    end

    // a flush cycle withdraws the offer immediately
    assign id_valid  = id_valid_q && !flush;
    assign id_instr  = instr_q;
    assign stall     = stall_q;
    assign busy_mask = busy_q;

`ifdef ID_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of cycles spent in HAZARD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if ((state == HAZARD) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
module tb_id_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        id_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic [31:0] busy_mask;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    id_issue_ctrl #(.NUM_REGS(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_ready  (if_ready),
        .id_valid  (id_valid),
        .id_instr  (id_instr),
        .id_ready  (id_ready),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush     (flush),
        .stall     (stall),
        .busy_mask (busy_mask),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic        rdy;
        logic        wbv;
        logic [4:0]  wbr;
        logic        fl;
        logic        e_iv;
        logic        e_st;
        logic [31:0] e_busy;
        logic [31:0] e_ins;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [4:0] rb,
                                        input logic [3:0] fn);
        return {op, rd, ra, rb, 7'b0, fn};
    endfunction

    function automatic vec_t mk(input logic iv, input logic [31:0] ins, input logic rdy,
                                input logic wbv, input logic [4:0] wbr, input logic fl,
                                input logic e_iv, input logic e_st, input logic [31:0] e_busy,
                                input logic [31:0] e_ins, input logic [15:0] e_cnt);
        vec_t v;
        v.iv = iv; v.ins = ins; v.rdy = rdy; v.wbv = wbv; v.wbr = wbr; v.fl = fl;
        v.e_iv = e_iv; v.e_st = e_st; v.e_busy = e_busy; v.e_ins = e_ins; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        if_valid = 1'b0;
        if_instr = '0;
        id_ready = 1'b0;
        wb_valid = 1'b0;
        wb_rd    = '0;
        flush    = 1'b0;
    endtask

    function automatic logic [15:0] cnt_exp(input logic [15:0] c);
`ifdef ID_STALL_CNT_EN
        return c;
`else
        return (c & 16'h0);
`endif
    endfunction

    logic [31:0] i1, i2, i3, i4, i5, i6, i7, i8, i9, i10;

    initial begin
        i1  = enc(6'b101010, 5'd3, 5'd1, 5'd2, 4'b0000); // r3 <- r1, r2
        i2  = enc(6'b101010, 5'd4, 5'd3, 5'd5, 4'b0000); // r4 <- r3, r5
        i3  = enc(6'b101010, 5'd5, 5'd1, 5'd4, 4'b1011); // r5 <- r1, imm
        i4  = enc(6'b101010, 5'd6, 5'd5, 5'd0, 4'b0000); // r6 <- r5, r0
        i5  = enc(6'b100000, 5'd7, 5'd0, 5'd0, 4'b0000); // ld r7
        i6  = enc(6'b100001, 5'd7, 5'd0, 5'd0, 4'b0000); // st r7
        i7  = enc(6'b100000, 5'd7, 5'd0, 5'd0, 4'b0000); // ld r7 again
        i8  = enc(6'b100000, 5'd6, 5'd0, 5'd0, 4'b0000); // ld r6
        i9  = enc(6'b101010, 5'd8, 5'd1, 5'd2, 4'b0000); // r8 <- r1, r2
        i10 = enc(6'b100000, 5'd9, 5'd0, 5'd0, 4'b0000); // ld r9

        //            iv  ins  rdy  wbv  wbr  fl   e_iv e_st e_busy       e_ins e_cnt
        vecs[0]  = mk(1, i1, 0, 0, 5'd0, 0,  1, 0, 32'h00000000, i1, 16'd0);
        vecs[1]  = mk(0, 0,  1, 0, 5'd0, 0,  0, 0, 32'h00000008, i1, 16'd0);
        vecs[2]  = mk(1, i2, 0, 0, 5'd0, 0,  0, 1, 32'h00000008, i2, 16'd0);
        vecs[3]  = mk(0, 0,  0, 0, 5'd0, 0,  0, 1, 32'h00000008, i2, 16'd1);
        vecs[4]  = mk(0, 0,  0, 1, 5'd3, 0,  1, 0, 32'h00000000, i2, 16'd2);
        vecs[5]  = mk(1, i3, 1, 0, 5'd0, 0,  1, 0, 32'h00000010, i3, 16'd2);
        vecs[6]  = mk(1, i4, 1, 0, 5'd0, 0,  0, 1, 32'h00000030, i4, 16'd2);
        vecs[7]  = mk(0, 0,  0, 0, 5'd0, 1,  0, 0, 32'h00000030, i4, 16'd3);
        vecs[8]  = mk(1, i5, 0, 0, 5'd0, 0,  1, 0, 32'h00000030, i5, 16'd3);
        vecs[9]  = mk(0, 0,  1, 0, 5'd0, 0,  0, 0, 32'h000000B0, i5, 16'd3);
        vecs[10] = mk(1, i6, 0, 0, 5'd0, 0,  0, 1, 32'h000000B0, i6, 16'd3);
        vecs[11] = mk(0, 0,  0, 1, 5'd9, 0,  0, 1, 32'h000000B0, i6, 16'd4);
        vecs[12] = mk(0, 0,  0, 1, 5'd7, 0,  1, 0, 32'h00000030, i6, 16'd5);
        vecs[13] = mk(1, i7, 1, 0, 5'd0, 0,  1, 0, 32'h00000030, i7, 16'd5);
        vecs[14] = mk(0, 0,  0, 0, 5'd0, 0,  1, 0, 32'h00000030, i7, 16'd5);
        vecs[15] = mk(0, 0,  1, 1, 5'd7, 0,  0, 0, 32'h000000B0, i7, 16'd5);
        vecs[16] = mk(1, i8, 0, 0, 5'd0, 0,  1, 0, 32'h000000B0, i8, 16'd5);
        vecs[17] = mk(1, i9, 1, 0, 5'd0, 0,  1, 0, 32'h000000F0, i9, 16'd5);

        idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("reset id_valid",  {31'b0, id_valid}, 32'd0);
        chk("reset stall",     {31'b0, stall},    32'd0);
        chk("reset busy_mask", busy_mask,         32'd0);
        chk("reset id_instr",  id_instr,          32'd0);
        chk("reset stall_cnt", {16'b0, stall_cnt}, 32'd0);
        chk("reset if_ready",  {31'b0, if_ready}, 32'd1);

        for (int i = 0; i < 18; i++) begin
            if_valid = vecs[i].iv;
            if_instr = vecs[i].ins;
            id_ready = vecs[i].rdy;
            wb_valid = vecs[i].wbv;
            wb_rd    = vecs[i].wbr;
            flush    = vecs[i].fl;
            @(posedge clk);
            #1 idle();
            #1;
            chk($sformatf("v%0d id_valid", i),  {31'b0, id_valid}, {31'b0, vecs[i].e_iv});
            chk($sformatf("v%0d stall", i),     {31'b0, stall},    {31'b0, vecs[i].e_st});
            chk($sformatf("v%0d busy_mask", i), busy_mask,         vecs[i].e_busy);
            chk($sformatf("v%0d if_ready", i),  {31'b0, if_ready},
                {31'b0, !vecs[i].e_iv && !vecs[i].e_st});
            chk($sformatf("v%0d stall_cnt", i), {16'b0, stall_cnt},
                {16'b0, cnt_exp(vecs[i].e_cnt)});
            if (vecs[i].e_iv)
                chk($sformatf("v%0d id_instr", i), id_instr, vecs[i].e_ins);
        end

        // asynchronous reset in the middle of an OFFER with busy 0xF0
        #1 rst = 1'b0;
        #1;
        chk("midrst id_valid",  {31'b0, id_valid}, 32'd0);
        chk("midrst busy_mask", busy_mask,         32'd0);
        chk("midrst stall_cnt", {16'b0, stall_cnt}, 32'd0);
        chk("midrst id_instr",  id_instr,          32'd0);
        chk("midrst stall",     {31'b0, stall},    32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("postrst if_ready", {31'b0, if_ready}, 32'd1);

        // fall-through ready, then flush beating an issue in OFFER
        if_valid = 1'b1;
        if_instr = i1;
        @(posedge clk);
        #1 idle();
        #1;
        chk("fl offer id_valid", {31'b0, id_valid}, 32'd1);
        id_ready = 1'b1;
        #1;
        chk("fl fallthru if_ready", {31'b0, if_ready}, 32'd1);
        flush = 1'b1;
        #1;
        chk("fl cycle if_ready", {31'b0, if_ready}, 32'd0);
        chk("fl cycle id_valid", {31'b0, id_valid}, 32'd0);
        @(posedge clk);
        #1 idle();
        #1;
        chk("fl after id_valid",  {31'b0, id_valid}, 32'd0);
        chk("fl after busy_mask", busy_mask,         32'd0);
        chk("fl after if_ready",  {31'b0, if_ready}, 32'd1);
        if_valid = 1'b1;
        if_instr = i10;
        @(posedge clk);
        #1 idle();
        #1;
        chk("fl next id_valid", {31'b0, id_valid}, 32'd1);
        chk("fl next id_instr", id_instr,          i10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
- Issue sequencer between instruction fetch and ID_stage.
- Holds one fetched instruction and tracks pending register writes in a busy scoreboard.
- Stalls the instruction while any source or destination register is still in flight, then offers it to ID with a valid/ready handshake.
- Releases scoreboard bits on write-back reports from WB.

Parameters:
NUM_REGS, 32, number of tracked architectural registers (index width fixed at 5 bits)
CNT_W, 16, stall counter width (used only with ID_STALL_CNT_EN)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
if_valid  input  1  fetched instruction valid
if_instr  input  [0:31]  fetched instruction, MSB-first bit numbering
if_ready  output  1  controller accepts if_instr this cycle
id_valid  output  1  held instruction offered to ID
id_instr  output  [0:31]  held instruction
id_ready  input  1  ID consumes id_instr this cycle
wb_valid  input  1  write-back completed this cycle
wb_rd  input  5  register written back
flush  input  1  squash held (not yet issued) instruction
stall  output  1  high while in HAZARD state
busy_mask  output  NUM_REGS  scoreboard; bit r = write to r pending
stall_cnt  output  CNT_W  hazard cycle count (zero when feature disabled)

Behaviour:
- Decode of the held instruction:
  - opcode [0:5] = 101010 (ALU): reads rA = [11:15] and rB = [16:20]; writes rD = [6:10].
  - ALU with funct [28:31] in {1011, 1101, 1111}: rB is an immediate, so only rA is read.
  - opcode 100000 (load): writes rD; no register reads.
  - opcode 100001 (store): reads rD [6:10] as store data; no write.
  - 111100 and all other opcodes: NOP; no reads, no writes.
- eff_mask = busy_mask with bit wb_rd cleared when wb_valid (write-back bypass).
- hazard = any read register set in eff_mask, or the write rD set in eff_mask (WAW).
- FSM states: EMPTY, HAZARD, OFFER.
  - EMPTY: if_ready = 1. On if_valid, capture if_instr and evaluate hazard on the captured instruction using eff_mask. Next state is HAZARD if hazard, else OFFER.
  - HAZARD: stall = 1; hazard is re-evaluated every cycle; go to OFFER when it clears. id_valid = 0.
  - OFFER: id_valid = 1, id_instr stable. On id_ready:
    - issue: set busy bit rD if the instruction writes.
    - if_ready = id_ready (fall-through), so a new capture may occur in the same cycle.
    - The new instruction's hazard check sees the rD bit set in that same cycle.
    - Next state is EMPTY, OFFER or HAZARD accordingly.
- Same-cycle issue set and wb clear on the same register: set wins.
- wb_valid for a register whose bit is already clear: ignored.
- flush: go to EMPTY next cycle. if_ready = 0 and id_valid = 0 in that cycle. Flush has priority over capture and issue. busy_mask is unaffected, because in-flight writes still complete.
- Reset (async, any state, mid-stall included):
  - state = EMPTY, id_valid = 0, id_instr = 0, busy_mask = 0, stall = 0, stall_cnt = 0.
  - if_ready = 1 after release.
- Latency: capture to id_valid is 1 cycle with no hazard; sustained throughput is 1 instruction per cycle with no hazards.

Optional Feature:
- ID_STALL_CNT_EN defined: stall_cnt increments every cycle with state = HAZARD and saturates at all-ones. It is cleared only by reset.
- ID_STALL_CNT_EN undefined: stall_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Shared package id_pkg:
  - opcode constants: OP_ALU = 6'b101010, OP_LD = 6'b100000, OP_ST = 6'b100001, OP_NOP = 6'b111100.
  - immediate-funct constants: 1011, 1101, 1111.
  - state enum: EMPTY, HAZARD, OFFER.
- Sub-module id_reg_use_dec: combinational decode producing rd_a_en, rd_a, rd_b_en, rd_b, wr_en, wr_rd. Reused by hazard check and issue.

Test Plan:
- ALU add r3 <- r1, r2 with empty scoreboard:
  - if_valid = 1 → id_valid = 1 next cycle.
  - On id_ready, busy_mask = 0x00000008.
- Back-to-back ALU r4 <- r3, r5 after r3 issued:
  - stall = 1, id_valid = 0.
  - wb_valid = 1, wb_rd = 3 → OFFER on the next cycle (bypass); stall_cnt counts stalled cycles when enabled.
- Immediate funct 1011 with [16:20] = 3 while r3 busy, rA = r1 free:
  - no stall; id_valid next cycle.
- Load r7 issued, then store reading r7 while busy:
  - HAZARD until wb_rd = 7.
  - If a new r7 write issues in the same cycle as the wb clear for r7, bit 7 stays set.
- flush asserted in HAZARD:
  - EMPTY next cycle, id_valid = 0, busy_mask unchanged.
  - The next if_valid is accepted.
- rst driven low mid-OFFER with busy_mask = 0x000000F0:
  - Immediately id_valid = 0, busy_mask = 0, stall_cnt = 0.
  - After release, if_ready = 1.
